// File: rtl/axi_slice_dc_isolate_ctrl.sv
// Isolation sequencer for the dual-clock AXI slave slice: closes AW/AR, drains W/B/R,
// then asserts isolate_o so no beat or response is lost when the slice is cut off.
module axi_slice_dc_isolate_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic isolate_req_i,
  output logic isolate_o,
  output logic draining_o,
  output logic err_o,
  input  logic up_aw_valid_i,
  output logic up_aw_ready_o,
  output logic dn_aw_valid_o,
  input  logic dn_aw_ready_i,
  input  logic up_ar_valid_i,
  output logic up_ar_ready_o,
  output logic dn_ar_valid_o,
  input  logic dn_ar_ready_i,
  input  logic w_valid_i,
  input  logic w_ready_i,
  input  logic w_last_i,
  input  logic b_valid_i,
  input  logic b_ready_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i
);

  typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic signed [CNT_W:0]   w_bal_q, w_bal_d;
  logic                    isolate_q, isolate_d;
  logic                    err_q, err_d;

  logic aw_open, ar_open;
  logic aw_hs, ar_hs, wl_hs, b_hs, rl_hs;
  logic drained;

  // Gates depend only on registered state so a request never cuts a handshake mid-cycle.
  assign aw_open = (state_q == RUN) && (wr_cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign ar_open = (state_q == RUN) && (rd_cnt_q < CNT_W'(MAX_OUTSTANDING));

  assign up_aw_ready_o = dn_aw_ready_i & aw_open;
  assign dn_aw_valid_o = up_aw_valid_i & aw_open;
  assign up_ar_ready_o = dn_ar_ready_i & ar_open;
  assign dn_ar_valid_o = up_ar_valid_i & ar_open;

  assign aw_hs = up_aw_valid_i & dn_aw_ready_i & aw_open;
  assign ar_hs = up_ar_valid_i & dn_ar_ready_i & ar_open;
  assign wl_hs = w_valid_i & w_ready_i & w_last_i;
  assign b_hs  = b_valid_i & b_ready_i;
  assign rl_hs = r_valid_i & r_ready_i & r_last_i;

  assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_bal_q == '0)
                   && !wl_hs && !b_hs && !rl_hs;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    w_bal_d  = w_bal_q;
    err_d    = err_q;

    if (state_q != ISOLATED) begin
      if (aw_hs && !b_hs) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end else if (b_hs && !aw_hs) begin
        if (wr_cnt_q == '0) err_d = 1'b1;
        else                wr_cnt_d = wr_cnt_q - CNT_W'(1);
      end

      if (ar_hs && !rl_hs) begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end else if (rl_hs && !ar_hs) begin
        if (rd_cnt_q == '0) err_d = 1'b1;
        else                rd_cnt_d = rd_cnt_q - CNT_W'(1);
      end

      // W may lead its AW, so the balance is allowed to go negative.
      if (aw_hs && !wl_hs)      w_bal_d = w_bal_q + (CNT_W+1)'(1);
      else if (wl_hs && !aw_hs) w_bal_d = w_bal_q - (CNT_W+1)'(1);
    end else if (b_hs || rl_hs || w_valid_i) begin
      err_d = 1'b1;
    end

    case (state_q)
      RUN:      if (isolate_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!isolate_req_i) state_d = RUN;
        else if (drained)   state_d = ISOLATED;
      end
      ISOLATED: if (!isolate_req_i) state_d = RUN;
      default:  state_d = RUN;
    endcase

    isolate_d = (state_d == ISOLATED);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      w_bal_q   <= '0;
      isolate_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      w_bal_q   <= w_bal_d;
      isolate_q <= isolate_d;
      err_q     <= err_d;
    end
  end

  assign isolate_o  = isolate_q;
  assign draining_o = (state_q == DRAIN);
  assign err_o      = err_q;

endmodule

// File: tb/tb_axi_slice_dc_isolate_ctrl.sv
// Randomized + directed bench; expected outputs come from a transaction-count model and are checked by a scoreboard.
module tb_axi_slice_dc_isolate_ctrl;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic req;
  logic iso, drn, err;
  logic up_aw_valid, up_aw_ready, dn_aw_valid, dn_aw_ready;
  logic up_ar_valid, up_ar_ready, dn_ar_valid, dn_ar_ready;
  logic w_valid, w_ready, w_last, b_valid, b_ready, r_valid, r_ready, r_last;

  always #5 clk = ~clk;

  axi_slice_dc_isolate_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .isolate_req_i(req),
    .isolate_o(iso), .draining_o(drn), .err_o(err),
    .up_aw_valid_i(up_aw_valid), .up_aw_ready_o(up_aw_ready),
    .dn_aw_valid_o(dn_aw_valid), .dn_aw_ready_i(dn_aw_ready),
    .up_ar_valid_i(up_ar_valid), .up_ar_ready_o(up_ar_ready),
    .dn_ar_valid_o(dn_ar_valid), .dn_ar_ready_i(dn_ar_ready),
    .w_valid_i(w_valid), .w_ready_i(w_ready), .w_last_i(w_last),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last)
  );

  // Reference model: outstanding transactions tracked as plain integers.
  bit m_draining, m_isolated, m_err;
  int m_writes, m_reads, m_wdebt;

  logic [6:0] sb[$];
  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  function automatic logic [6:0] expected();
    bit running, aw_ok, ar_ok;
    running = !m_draining && !m_isolated;
    aw_ok   = running && (m_writes < MAXO);
    ar_ok   = running && (m_reads  < MAXO);
    return {m_isolated, m_draining, m_err,
            dn_aw_ready & aw_ok, up_aw_valid & aw_ok,
            dn_ar_ready & ar_ok, up_ar_valid & ar_ok};
  endfunction

  function automatic bit bit_rand(int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic model_step();
    bit running, aw, ar, wl, b, rl, empty;
    if (!rst_n) begin
      m_draining = 0; m_isolated = 0; m_err = 0;
      m_writes = 0; m_reads = 0; m_wdebt = 0;
      return;
    end
    running = !m_draining && !m_isolated;
    aw = up_aw_valid && dn_aw_ready && running && (m_writes < MAXO);
    ar = up_ar_valid && dn_ar_ready && running && (m_reads  < MAXO);
    wl = w_valid && w_ready && w_last;
    b  = b_valid && b_ready;
    rl = r_valid && r_ready && r_last;
    if (m_isolated) begin
      if (b || rl || w_valid) m_err = 1;
      if (!req) m_isolated = 0;
      return;
    end
    empty = (m_writes == 0) && (m_reads == 0) && (m_wdebt == 0) && !wl && !b && !rl;
    if (m_writes + int'(aw) - int'(b) < 0) m_err = 1;
    else m_writes = m_writes + int'(aw) - int'(b);
    if (m_reads + int'(ar) - int'(rl) < 0) m_err = 1;
    else m_reads = m_reads + int'(ar) - int'(rl);
    m_wdebt = m_wdebt + int'(aw) - int'(wl);
    if (!m_draining) begin
      m_draining = req;
    end else if (!req) begin
      m_draining = 0;
    end else if (empty) begin
      m_draining = 0;
      m_isolated = 1;
    end
  endtask

  task automatic cyc();
    sb.push_back(expected());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    up_aw_valid = 0; dn_aw_ready = 0; up_ar_valid = 0; dn_ar_ready = 0;
    w_valid = 0; w_ready = 0; w_last = 0; b_valid = 0; b_ready = 0;
    r_valid = 0; r_ready = 0; r_last = 0;
  endtask

  // Monitor: one expected output vector per cycle, compared mid-cycle.
  initial begin
    logic [6:0] e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {iso, drn, err, up_aw_ready, dn_aw_valid, up_ar_ready, dn_ar_valid};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs{iso,drn,err,awr,awv,arr,arv} t=%0t got=%b exp=%b", $time, a, e);
        end
      end
    end
  end

  // Epoch table: {aw%, b%, req_toggle%}
  int ep_tab[8][3] = '{'{80, 10, 0}, '{90, 0, 0}, '{50, 50, 4}, '{30, 70, 6},
                       '{70, 30, 3}, '{20, 90, 8}, '{60, 60, 5}, '{40, 40, 10}};

  initial begin
    rst_n = 0; req = 0; idle_inputs();
    @(posedge clk); model_step(); #1;
    cyc();
    rst_n = 1;

    for (int ep = 0; ep < 8; ep++) begin
      for (int c = 0; c < 200; c++) begin
        if (bit_rand(ep_tab[ep][2])) req = ~req;
        up_aw_valid = bit_rand(ep_tab[ep][0]);
        dn_aw_ready = bit_rand(75);
        up_ar_valid = bit_rand(ep_tab[ep][0]);
        dn_ar_ready = bit_rand(75);
        b_valid = !m_isolated && (m_writes > 0) && bit_rand(ep_tab[ep][1]);
        b_ready = bit_rand(80);
        r_valid = !m_isolated && bit_rand(60);
        r_ready = bit_rand(80);
        r_last  = (m_reads > 0) && bit_rand(ep_tab[ep][1]);
        w_valid = !m_isolated && bit_rand(50);
        w_ready = bit_rand(80);
        w_last  = (m_wdebt > 0) ? bit_rand(60) : bit_rand(3);
        cyc();
      end
      req = 0; idle_inputs();
      rst_n = 0; cyc(); rst_n = 1;
    end

    // Idle request: drain then isolate two cycles later, gates closed.
    req = 1; up_aw_valid = 1;
    repeat (4) cyc();
    req = 0; cyc(); cyc();

    // Three writes and two reads outstanding, responses returned one by one.
    dn_aw_ready = 1; dn_ar_ready = 1; up_ar_valid = 1;
    cyc(); cyc(); up_ar_valid = 0; cyc();
    up_aw_valid = 0; w_valid = 1; w_ready = 1; w_last = 1;
    repeat (3) cyc();
    w_valid = 0; req = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      b_valid = 1; b_ready = 1; cyc(); b_valid = 0; cyc();
    end
    for (int i = 0; i < 2; i++) begin
      r_valid = 1; r_ready = 1; r_last = 1; cyc(); r_valid = 0; cyc();
    end
    repeat (2) cyc();

    // Response while isolated: sticky error.
    b_valid = 1; b_ready = 1; cyc(); b_valid = 0;
    req = 0; repeat (3) cyc();

    // Read outstanding, aborted drain, then reset mid-drain.
    up_ar_valid = 1; cyc(); up_ar_valid = 0;
    req = 1; cyc(); cyc(); req = 0; cyc(); cyc();
    req = 1; cyc(); cyc();
    rst_n = 0; cyc(); rst_n = 1; req = 0;
    up_ar_valid = 1; up_aw_valid = 1; repeat (3) cyc();
    idle_inputs(); cyc();

    @(negedge clk); @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
